// File: rtl/delayed_trigger_scheduler.sv
// delayed_trigger_scheduler
// One programmable down-counter shared by N_CH trigger channels. A rising
// edge on enable[i] latches a request; requests are granted one at a time in
// round-robin order, the sampled delay is counted out, and a single-cycle
// pulse is emitted on trigger[i].
module delayed_trigger_scheduler #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 8,
    parameter int CH_W  = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_CH-1:0]   enable,
    input  logic [CNT_W-1:0]  delay,
    output logic [N_CH-1:0]   trigger,
    output logic              busy,
    output logic [CH_W-1:0]   active_ch,
    output logic [N_CH-1:0]   pending,
    output logic [N_CH-1:0]   overrun
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_FIRE = 2'd2;

    logic [1:0]        state_reg,     state_next;
    logic [CNT_W-1:0]  cnt_reg,       cnt_next;
    logic [CH_W-1:0]   active_ch_reg, active_ch_next;
    logic [CH_W-1:0]   last_reg,      last_next;
    logic [N_CH-1:0]   trigger_reg,   trigger_next;
    logic [N_CH-1:0]   pending_reg,   pending_next;
    logic [N_CH-1:0]   overrun_reg,   overrun_next;
    logic [N_CH-1:0]   enable_q_reg;

    logic [N_CH-1:0]   rise;
    logic [N_CH-1:0]   grant_onehot;
    logic [N_CH-1:0]   fire_onehot;
    logic [N_CH-1:0]   pend_rot;
    logic [2*N_CH-1:0] pend_dbl;
    logic [CH_W-1:0]   winner;
    logic              winner_valid;
    logic              grant_en;

    // ------------------------------------------------------------------
    // Round-robin arbiter
    // pending is rotated so that bit 0 is the channel just after the last
    // serviced one; the lowest set bit of the rotated vector is the winner.
    // ------------------------------------------------------------------

    // Rotate pending so the search always starts at (last + 1) mod N_CH
    always_comb begin
        pend_dbl = {pending_reg, pending_reg} >> (int'(last_reg) + 1);
        pend_rot = pend_dbl[N_CH-1:0];
    end

    // Pick the first requesting channel at or after the search start
    always_comb begin
        winner_valid = 1'b0;
        winner       = '0;
        for (int j = 0; j < N_CH; j++) begin
            if (!winner_valid && pend_rot[j]) begin
                winner_valid = 1'b1;
                winner       = CH_W'((int'(last_reg) + 1 + j) % N_CH);
            end
        end
    end

    // A grant only happens from IDLE; the counter is shared, so one at a time
    assign grant_en = (state_reg == ST_IDLE) && winner_valid;

    // ------------------------------------------------------------------
    // Per-channel request bookkeeping
    // A rise at the same edge as the grant re-arms the channel (set wins).
    // A rise on a channel already waiting for its grant merges into it and
    // is reported on overrun; the granted channel never reports overrun.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            assign rise[gi]         = enable[gi] & ~enable_q_reg[gi];
            assign grant_onehot[gi] = grant_en && (winner == CH_W'(gi));
            assign fire_onehot[gi]  = (active_ch_reg == CH_W'(gi));
            assign pending_next[gi] = rise[gi] | (pending_reg[gi] & ~grant_onehot[gi]);
            assign overrun_next[gi] = rise[gi] & pending_reg[gi] & ~grant_onehot[gi];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Control FSM: IDLE -> WAIT (count delay) -> FIRE (pulse) -> IDLE
    // The counter is loaded with delay at grant; a loaded value of 0 or 1
    // both fire on the first WAIT cycle, so delay 0 behaves as 1.
    // ------------------------------------------------------------------

    // Next-state, counter and trigger decode
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        active_ch_next = active_ch_reg;
        last_next      = last_reg;
        trigger_next   = '0;
        case (state_reg)
            ST_IDLE: begin
                if (grant_en) begin
                    active_ch_next = winner;
                    cnt_next       = delay;
                    state_next     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_reg <= CNT_W'(1)) begin
                    trigger_next = fire_onehot;
                    state_next   = ST_FIRE;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            ST_FIRE: begin
                // Round-robin pointer advances only once service completes
                last_next  = active_ch_reg;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Register all state; reset aborts any service and drops every request
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            active_ch_reg <= '0;
            last_reg      <= CH_W'(N_CH - 1);
            trigger_reg   <= '0;
            pending_reg   <= '0;
            overrun_reg   <= '0;
            enable_q_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            active_ch_reg <= active_ch_next;
            last_reg      <= last_next;
            trigger_reg   <= trigger_next;
            pending_reg   <= pending_next;
            overrun_reg   <= overrun_next;
            enable_q_reg  <= enable;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign trigger   = trigger_reg;
    assign busy      = (state_reg != ST_IDLE);
    assign active_ch = active_ch_reg;
    assign pending   = pending_reg;
    assign overrun   = overrun_reg;

endmodule

// File: tb/tb_delayed_trigger_scheduler.sv
// Scoreboard bench for delayed_trigger_scheduler. The driver predicts each
// edge with a timestamp-based reference (when the shared timer is free, who
// wins, when the pulse lands) and queues the expectations; a monitor pops
// and compares them just after each rising edge.
module tb_delayed_trigger_scheduler;

    localparam int N_CH  = 4;
    localparam int CNT_W = 8;
    localparam int CH_W  = $clog2(N_CH);

    logic              clk = 1'b0;
    logic              rst;
    logic [N_CH-1:0]   enable;
    logic [CNT_W-1:0]  delay;
    logic [N_CH-1:0]   trigger;
    logic              busy;
    logic [CH_W-1:0]   active_ch;
    logic [N_CH-1:0]   pending;
    logic [N_CH-1:0]   overrun;

    delayed_trigger_scheduler #(.N_CH(N_CH), .CNT_W(CNT_W), .CH_W(CH_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .delay     (delay),
        .trigger   (trigger),
        .busy      (busy),
        .active_ch (active_ch),
        .pending   (pending),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // ---------------- scoreboard queues ----------------
    typedef struct { int ch; int t; } trig_exp_t;
    typedef struct { logic [N_CH-1:0] mask; int t; } ov_exp_t;
    typedef struct { int t; logic [N_CH-1:0] pend; logic bsy; int act; } st_exp_t;

    trig_exp_t trig_q[$];
    ov_exp_t   ov_q[$];
    st_exp_t   st_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_cnt, act, exp);
    endfunction

    // ---------------- reference model ----------------
    logic [N_CH-1:0] m_pending;
    logic [N_CH-1:0] m_enq;
    int m_last, m_active, m_free_at, m_busy_until;

    function automatic void model_reset();
        m_pending    = '0;
        m_enq        = '0;
        m_last       = N_CH - 1;
        m_active     = 0;
        m_free_at    = 0;
        m_busy_until = -1;
    endfunction

    // Predict what the scheduler does at rising edge t with these inputs
    function automatic void model_step(input int t, input logic [N_CH-1:0] en,
                                       input logic [CNT_W-1:0] dly, input logic r);
        logic [N_CH-1:0] rise;
        int grant;
        int d;
        st_exp_t s;
        if (r) begin
            model_reset();
            trig_q.delete();
            ov_q.delete();
            s.t = t; s.pend = '0; s.bsy = 1'b0; s.act = 0;
            st_q.push_back(s);
            return;
        end
        rise  = en & ~m_enq;
        grant = -1;
        if (t >= m_free_at && m_pending != 0) begin
            for (int o = 1; o <= N_CH; o++) begin
                if (grant < 0 && m_pending[(m_last + o) % N_CH]) grant = (m_last + o) % N_CH;
            end
        end
        if (grant >= 0) begin
            d = (dly == 0) ? 1 : int'(dly);
            trig_q.push_back('{ch: grant, t: t + d});
            m_free_at    = t + d + 2;
            m_busy_until = t + d;
            m_last       = grant;
            m_active     = grant;
            m_pending[grant] = 1'b0;
        end
        if ((rise & m_pending) != 0) ov_q.push_back('{mask: rise & m_pending, t: t});
        m_pending = m_pending | rise;
        m_enq     = en;
        s.t = t; s.pend = m_pending; s.bsy = (t <= m_busy_until); s.act = m_active;
        st_q.push_back(s);
    endfunction

    // ---------------- driver helpers ----------------
    logic [N_CH-1:0]  en_cur;
    logic [CNT_W-1:0] dly_cur;

    task automatic step(input logic [N_CH-1:0] en, input logic [CNT_W-1:0] dly, input logic r);
        @(negedge clk);
        enable = en;
        delay  = dly;
        rst    = r;
        model_step(edge_cnt + 1, en, dly, r);
    endtask

    task automatic idle(input int n);
        repeat (n) step(en_cur, dly_cur, 1'b0);
    endtask

    // Idle with delay scrambled every cycle; only the grant-time value matters
    task automatic idle_rand(input int n);
        repeat (n) begin
            dly_cur = CNT_W'($urandom_range(0, 255));
            step(en_cur, dly_cur, 1'b0);
        end
    endtask

    task automatic pulse(input logic [N_CH-1:0] mask, input logic [CNT_W-1:0] dly);
        dly_cur = dly;
        en_cur  = en_cur | mask;
        step(en_cur, dly_cur, 1'b0);
        en_cur  = en_cur & ~mask;
        step(en_cur, dly_cur, 1'b0);
    endtask

    // ---------------- monitor ----------------
    initial begin
        trig_exp_t te;
        ov_exp_t   oe;
        st_exp_t   se;
        forever begin
            @(posedge clk);
            #1;
            while (trig_q.size() > 0 && trig_q[0].t < edge_cnt) begin
                check("trigger_missing_edge", 32'(edge_cnt), 32'(trig_q[0].t));
                void'(trig_q.pop_front());
            end
            if (trigger != 0) begin
                if (trig_q.size() == 0) check("trigger_unexpected", 32'(trigger), 32'd0);
                else begin
                    te = trig_q.pop_front();
                    check("trigger_value", 32'(trigger), 32'(1) << te.ch);
                    check("trigger_edge", 32'(edge_cnt), 32'(te.t));
                end
            end
            while (ov_q.size() > 0 && ov_q[0].t < edge_cnt) begin
                check("overrun_missing_edge", 32'(edge_cnt), 32'(ov_q[0].t));
                void'(ov_q.pop_front());
            end
            if (overrun != 0) begin
                if (ov_q.size() == 0) check("overrun_unexpected", 32'(overrun), 32'd0);
                else begin
                    oe = ov_q.pop_front();
                    check("overrun_value", 32'(overrun), 32'(oe.mask));
                    check("overrun_edge", 32'(edge_cnt), 32'(oe.t));
                end
            end
            if (st_q.size() > 0 && st_q[0].t == edge_cnt) begin
                se = st_q.pop_front();
                check("pending", 32'(pending), 32'(se.pend));
                check("busy", 32'(busy), 32'(se.bsy));
                check("active_ch", 32'(active_ch), 32'(se.act));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; enable = '0; delay = '0;
        en_cur = '0; dly_cur = '0;
        model_reset();
        repeat (3) step('0, '0, 1'b1);

        // enable already high when reset releases counts as a rise
        en_cur = 4'b1000; dly_cur = 8'd2;
        step(en_cur, dly_cur, 1'b1);
        idle(8);
        en_cur = '0; idle(2);

        // single request, delay 5
        pulse(4'b0001, 8'd5); idle(12);

        // all channels at once, delay 3
        pulse(4'b1111, 8'd3); idle(24);

        // delay boundaries; delay changes during WAIT must be ignored
        pulse(4'b0001, 8'd0); idle(5);
        pulse(4'b0010, 8'd1); idle(5);
        pulse(4'b0100, 8'd255); idle_rand(270);
        dly_cur = 8'd4; idle(4);

        // overrun: two rises on ch1 while ch0 waits
        pulse(4'b0001, 8'd10); pulse(4'b0010, 8'd10); idle(1); pulse(4'b0010, 8'd10); idle(20);

        // fairness: ch0 keeps re-requesting while ch2 waits
        pulse(4'b0101, 8'd4);
        repeat (4) begin
            idle(2); pulse(4'b0001, 8'd4); idle(3);
        end
        idle(20);

        // reset during WAIT with ch1/ch2 pending, then normal service of ch2
        pulse(4'b0001, 8'd20); pulse(4'b0110, 8'd20); idle(3);
        step(en_cur, dly_cur, 1'b1);
        idle(4);
        pulse(4'b0100, 8'd6); idle(12);

        // randomized traffic
        repeat (2000) begin
            for (int c = 0; c < N_CH; c++) begin
                if ($urandom_range(0, 11) == 0) en_cur[c] = ~en_cur[c];
            end
            dly_cur = ($urandom_range(0, 19) == 0) ? CNT_W'($urandom_range(0, 40))
                                                   : CNT_W'($urandom_range(0, 6));
            if ($urandom_range(0, 499) == 0) step(en_cur, dly_cur, 1'b1);
            else step(en_cur, dly_cur, 1'b0);
        end

        // drain
        en_cur = '0; dly_cur = 8'd1;
        idle(400);
        @(posedge clk);
        #2;
        check("trig_queue_drained", 32'(trig_q.size()), 32'd0);
        check("overrun_queue_drained", 32'(ov_q.size()), 32'd0);
        check("status_queue_drained", 32'(st_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/delayed_trigger_scheduler.md
# delayed_trigger_scheduler

Shares one programmable delay counter among N_CH trigger channels. Each channel requests on a rising edge of its `enable` bit. The scheduler grants channels one at a time in round-robin order, counts the sampled `delay` in `clk` cycles, then emits a one-cycle pulse on that channel's `trigger` bit. It sits between the stimulus and enable sources and the blocks that consume delayed triggers, replacing per-channel wait-on-clock logic with one arbitrated timer.

## Interface
- `N_CH`, 4: number of requesting channels (≥2).
- `CNT_W`, 8: width of `delay` and of the internal counter.
- `CH_W`, $clog2(N_CH): width of `active_ch`.
- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  N_CH  per-channel request; a rising edge (0→1 between two sampling edges) posts one request.
- `delay`  in  CNT_W  wait length in cycles; sampled only at grant.
- `trigger`  out  N_CH  registered one-cycle pulse on the serviced channel; at most one bit high.
- `busy`  out  1  high whenever state ≠ IDLE.
- `active_ch`  out  CH_W  index of the last granted channel; holds its value in IDLE.
- `pending`  out  N_CH  latched, not-yet-granted requests.
- `overrun`  out  N_CH  registered one-cycle pulse: a request was merged into an already-pending one.

## Operation
- Edge detect: `enable_q <= enable` every edge; `rise = enable & ~enable_q`.
- An `enable` bit already high when reset releases counts as a rise on the first edge after reset.
- `pending[i]` is set at any edge where `rise[i]` is 1.
- `pending[i]` is cleared at the edge where channel i is granted. If `rise[i]` is 1 at that same edge, set wins and the channel re-arms.
- `overrun[i]` pulses when `rise[i]` is 1 while `pending[i]` is 1 and i is not being granted that edge. Pending stays 1: the requests merge and only one trigger results.
- A rise on the channel currently in WAIT or FIRE is a new request, not an overrun.
- Arbiter: search `pending` starting at `(last + 1) mod N_CH`, wrapping; take the first set bit. `last` resets to N_CH−1, so ch0 has first priority out of reset.
- FSM, three states:
  - IDLE: if `pending` ≠ 0, grant the winner. Set `active_ch` to it, load `cnt <= delay`, clear its pending bit, go to WAIT.
  - WAIT: if `cnt` ≤ 1, set `trigger[active_ch] <= 1` and go to FIRE; else `cnt <= cnt − 1`. Changes to `delay` here are ignored.
  - FIRE: `trigger <= 0`, `last <= active_ch`, go to IDLE.
- `delay` = 0 behaves exactly as 1.
- Reset values: state IDLE, `cnt` 0, `trigger` 0, `pending` 0, `overrun` 0, `active_ch` 0, `enable_q` 0, `last` N_CH−1, `busy` 0.
- Reset mid-operation aborts immediately. No trigger is issued and all pending requests are dropped.

## Timing
- Let a rise be sampled at edge k, with the scheduler idle and no other requests pending:
  - `pending` is high after edge k.
  - Grant happens at edge k+1.
  - `trigger` is high from edge k+1+D to edge k+2+D, where D = max(delay, 1).
  - State returns to IDLE at edge k+2+D.
- Back-to-back service: consecutive triggers are D+2 cycles apart, because each FIRE is followed by one IDLE cycle before the next grant.
- `busy` rises after the grant edge and falls after the FIRE edge, so it is high for D+1 cycles.
- `overrun` is high for exactly one cycle, following the edge that detected it.
- Latency through the scheduler is fixed: it depends only on D and on the queue ahead of the request, never on input timing within a cycle.

## Test plan
- Single request: delay=5, `enable[0]` rise sampled at edge 10 → `pending[0]` set after edge 10. Grant at edge 11; `trigger` is 0001 only between edges 16 and 17; `busy` high after edges 11–16; `active_ch`=0.
- Simultaneous request: all four channels rise at edge k, delay=3 → triggers in order ch0, ch1, ch2, ch3. Pulse start edges are k+4, k+9, k+14, k+19; `pending` steps 1111→1110→1100→1000→0000.
- Fairness: ch0 re-requests during every service while ch2 is pending → grant order 0,2,0,2; ch0 never wins twice in a row while ch2 is pending.
- Delay boundaries: delay=0 and delay=1 each give a trigger after edge k+2. Delay=255 gives a trigger after edge k+256. Changing `delay` during WAIT leaves timing unchanged.
- Overrun: two rises on ch1 while ch0 is in WAIT → `overrun[1]` pulses once at the second rise; exactly one `trigger[1]` pulse follows.
- Reset mid-WAIT: assert `rst` for one edge during WAIT with `pending`=0110 → all outputs read reset values the next cycle; no trigger ever appears; the next rise on ch2 is served with normal latency.
